// File: rtl/spi_bridge_pkg.sv
// Shared constants for the 3-wire SPI bridge slave: frame geometry, register map
// and bit positions within the shift word.
package spi_bridge_pkg;

    localparam int unsigned SpiCommandLen = 16;
    localparam int unsigned SpiDataLen    = 8;
    localparam int unsigned AddrW         = 5;
    localparam int unsigned DataW         = 8;
    localparam int unsigned NumRegs       = 32;
    localparam int unsigned CntW          = 5;

    localparam logic [7:0]  ChipIdDefault = 8'h92;

    localparam int unsigned RwBit   = 0;
    localparam int unsigned AddrLsb = 1;
    localparam int unsigned AddrMsb = 5;

endpackage

// File: rtl/spi_3w_regfile.sv
// 32 x 8 register file; register 0 is a read-only chip ID, the rest clear on reset.
module spi_3w_regfile
    import spi_bridge_pkg::*;
#(
    parameter logic [DataW-1:0] ChipId = ChipIdDefault
) (
    input  logic             SPI_CLK,
    input  logic             nReset,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [1:NumRegs-1];

    always_ff @(posedge SPI_CLK or negedge nReset) begin
        if (!nReset) begin
            for (int i = 1; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (raddr_i == '0) ? ChipId : mem_q[raddr_i];

endmodule

// File: rtl/spi_3w_slave.sv
// 3-wire SPI register slave: LSB-first command/address/data frames, write commit on
// the last rising edge, read data driven on falling edges through SDIO_OE.
module spi_3w_slave
    import spi_bridge_pkg::*;
#(
    parameter int unsigned      SPI_Command_Len = SpiCommandLen,
    parameter int unsigned      SPI_Data_Len    = SpiDataLen,
    parameter logic [DataW-1:0] Chip_ID         = ChipIdDefault
) (
    input  logic             SPI_CLK,
    input  logic             nReset,
    input  logic             nCS,
    input  logic             SDIO_In,
    output logic             SDIO_Out,
    output logic             SDIO_OE,
    output logic [AddrW-1:0] Reg_Addr_Last,
    output logic             Write_Strobe
);

    localparam int unsigned     FrameLen = SPI_Command_Len + SPI_Data_Len;
    localparam int unsigned     TxIdxW   = $clog2(DataW);
    localparam logic [CntW-1:0] TxCnt    = CntW'(SPI_Command_Len - 1);
    localparam logic [CntW-1:0] CmdCnt   = CntW'(SPI_Command_Len);
    localparam logic [CntW-1:0] LastCnt  = CntW'(FrameLen - 1);
    localparam logic [CntW-1:0] EndCnt   = CntW'(FrameLen);

    logic                frame_rst_n;
    logic                blocked_q;
    logic [CntW-1:0]     cnt_q;
    logic [FrameLen-1:0] shift_q;
    logic [DataW-1:0]    tx_q;
    logic [DataW-1:0]    rd_data;
    logic [DataW-1:0]    wr_data;
    logic [AddrW-1:0]    addr;
    logic [AddrW-1:0]    addr_last_q;
    logic                is_read;
    logic                commit;
    logic                wr_en;
    logic                strobe_q;
    logic [TxIdxW-1:0]   tx_idx;
    logic                oe_d, oe_q;
    logic                out_d, out_q;
    logic                unused_shift;

    // Deselect or reset clears all per-frame state immediately.
    assign frame_rst_n = nReset & ~nCS;

    assign is_read = shift_q[RwBit];
    assign addr    = shift_q[AddrMsb:AddrLsb];
    assign wr_data = {SDIO_In, shift_q[FrameLen-2:SPI_Command_Len]};
    assign commit  = !blocked_q && (cnt_q == LastCnt);
    assign wr_en   = commit && !is_read;
    assign tx_idx  = TxIdxW'(cnt_q - CmdCnt);

    assign unused_shift = ^{shift_q[FrameLen-1], shift_q[SPI_Command_Len-1:AddrMsb+1]};

    // A reset landing inside a frame locks out the rest of it until nCS rises.
    always_ff @(negedge nReset or posedge nCS) begin
        if (!nReset) begin
            blocked_q <= ~nCS;
        end else begin
            blocked_q <= 1'b0;
        end
    end

    always_ff @(posedge SPI_CLK or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
            tx_q    <= '0;
        end else if (!blocked_q && (cnt_q != EndCnt)) begin
            cnt_q          <= cnt_q + 1'b1;
            shift_q[cnt_q] <= SDIO_In;
            if (cnt_q == TxCnt) begin
                tx_q <= rd_data;
            end
        end
    end

    always_ff @(posedge SPI_CLK or negedge nReset) begin
        if (!nReset) begin
            strobe_q    <= 1'b0;
            addr_last_q <= '0;
        end else begin
            strobe_q <= wr_en;
            if (commit) begin
                addr_last_q <= addr;
            end
        end
    end

    always_comb begin
        oe_d  = 1'b0;
        out_d = 1'b0;
        if (is_read && (cnt_q >= CmdCnt) && (cnt_q < EndCnt)) begin
            oe_d  = 1'b1;
            out_d = tx_q[tx_idx];
        end
    end

    always_ff @(negedge SPI_CLK or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            oe_q  <= 1'b0;
            out_q <= 1'b0;
        end else begin
            oe_q  <= oe_d;
            out_q <= out_d;
        end
    end

    spi_3w_regfile #(
        .ChipId (Chip_ID)
    ) u_regfile (
        .SPI_CLK (SPI_CLK),
        .nReset  (nReset),
        .we_i    (wr_en),
        .waddr_i (addr),
        .wdata_i (wr_data),
        .raddr_i (addr),
        .rdata_o (rd_data)
    );

    assign SDIO_OE       = oe_q;
    assign SDIO_Out      = out_q & oe_q;
    assign Write_Strobe  = strobe_q;
    assign Reg_Addr_Last = addr_last_q;

endmodule

// File: tb/tb_spi_3w_slave.sv
// Bench for spi_3w_slave: frame-level reference model with a per-edge compare process.
module tb_spi_3w_slave;

    logic       SPI_CLK;
    logic       nReset;
    logic       nCS;
    logic       SDIO_In;
    logic       SDIO_Out;
    logic       SDIO_OE;
    logic [4:0] Reg_Addr_Last;
    logic       Write_Strobe;

    int errors = 0;
    int checks = 0;
    int strobes = 0;

    // Reference model state, described in terms of edges seen in the current frame.
    int         m_rise = 0;
    bit         m_last_rise = 0;
    bit         m_active = 1;
    bit         m_read = 0;
    logic [7:0] m_rdata = 8'h00;
    logic [7:0] mem [32];
    logic [4:0] addr_last_exp = 5'd0;
    bit         cmp_en = 0;

    spi_3w_slave dut (
        .SPI_CLK       (SPI_CLK),
        .nReset        (nReset),
        .nCS           (nCS),
        .SDIO_In       (SDIO_In),
        .SDIO_Out      (SDIO_Out),
        .SDIO_OE       (SDIO_OE),
        .Reg_Addr_Last (Reg_Addr_Last),
        .Write_Strobe  (Write_Strobe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge Write_Strobe) strobes++;

    always @(SPI_CLK) begin
        int idx;
        bit valid;
        #2;
        if (cmp_en) begin
            idx   = m_last_rise ? m_rise - 17 : m_rise - 16;
            valid = m_active && m_read && (idx >= 0) && (idx < 8);
            check("sdio_oe", SDIO_OE, valid);
            check("sdio_out", SDIO_Out, valid ? m_rdata[idx] : 1'b0);
            check("write_strobe", Write_Strobe, m_active && !m_read && (m_rise == 24));
            check("reg_addr_last", Reg_Addr_Last, addr_last_exp);
        end
    end

    task automatic frame(input bit rd, input logic [4:0] addr, input logic [7:0] data,
                         input int nclk, input int rst_at, output logic [7:0] cap);
        logic [23:0] w;
        w = {data, 10'($urandom), addr, rd};
        cap = 8'h00;
        m_read = rd;
        m_rdata = (addr == 5'd0) ? 8'h92 : mem[addr];
        m_rise = 0;
        m_last_rise = 0;
        nCS = 1'b0;
        #5;
        for (int i = 0; i < nclk; i++) begin
            SDIO_In = (i < 24) ? w[i] : 1'($urandom);
            #5;
            SPI_CLK = 1'b1;
            m_rise++;
            m_last_rise = 1;
            if (m_rise == 24 && m_active) begin
                addr_last_exp = addr;
                if (!rd && addr != 5'd0) mem[addr] = data;
            end
            #2;
            if (m_rise >= 17 && m_rise <= 24) cap[m_rise-17] = SDIO_Out;
            #1;
            if (m_rise == rst_at) begin
                nReset = 1'b0;
                m_active = 0;
                for (int k = 0; k < 32; k++) mem[k] = 8'h00;
                addr_last_exp = 5'd0;
                #1;
                check("oe_in_reset", SDIO_OE, 1'b0);
                check("out_in_reset", SDIO_Out, 1'b0);
                check("addr_last_in_reset", Reg_Addr_Last, 5'd0);
                nReset = 1'b1;
            end else begin
                #1;
            end
            #1;
            SPI_CLK = 1'b0;
            m_last_rise = 0;
        end
        #5;
        nCS = 1'b1;
        #1;
        check("oe_after_ncs", SDIO_OE, 1'b0);
        check("out_after_ncs", SDIO_Out, 1'b0);
        m_active = 1;
        m_rise = 0;
        #4;
    endtask

    initial begin
        logic [7:0] c;
        logic [7:0] exp;
        int s0;
        bit rd;
        logic [4:0] a;
        logic [7:0] d;
        int n;

        for (int k = 0; k < 32; k++) mem[k] = 8'h00;
        SPI_CLK = 1'b0;
        nCS = 1'b1;
        SDIO_In = 1'b0;
        nReset = 1'b0;
        #10;
        check("reset_oe", SDIO_OE, 1'b0);
        check("reset_out", SDIO_Out, 1'b0);
        check("reset_strobe", Write_Strobe, 1'b0);
        check("reset_addr_last", Reg_Addr_Last, 5'd0);
        nReset = 1'b1;
        #5;
        cmp_en = 1;

        s0 = strobes;
        frame(0, 5'd5, 8'hA5, 24, 0, c);
        check("w5_addr_last", Reg_Addr_Last, 5'd5);
        check("w5_strobes", strobes - s0, 1);
        frame(1, 5'd5, 8'h00, 24, 0, c);
        check("r5_data", c, 8'hA5);

        frame(1, 5'd0, 8'h00, 24, 0, c);
        check("r0_chip_id", c, 8'h92);
        frame(0, 5'd0, 8'h00, 24, 0, c);
        frame(1, 5'd0, 8'h00, 24, 0, c);
        check("r0_after_write", c, 8'h92);

        s0 = strobes;
        frame(0, 5'd9, 8'h5A, 30, 0, c);
        check("w9_long_strobes", strobes - s0, 1);
        check("w9_addr_last", Reg_Addr_Last, 5'd9);

        s0 = strobes;
        frame(0, 5'd7, 8'h3C, 20, 0, c);
        check("abort_strobes", strobes - s0, 0);
        check("abort_addr_last", Reg_Addr_Last, 5'd9);
        frame(1, 5'd7, 8'h00, 24, 0, c);
        check("r7_unchanged", c, 8'h00);
        frame(1, 5'd9, 8'h00, 24, 0, c);
        check("r9_data", c, 8'h5A);

        for (int t = 0; t < 40; t++) begin
            rd = 1'($urandom);
            a = 5'($urandom);
            d = 8'($urandom);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : 24;
            exp = (a == 5'd0) ? 8'h92 : mem[a];
            frame(rd, a, d, n, 0, c);
            if (rd && n >= 24) check("rand_read", c, exp);
        end

        frame(1, 5'd1, 8'h00, 24, 19, c);
        for (int k = 1; k < 32; k++) begin
            frame(1, 5'(k), 8'h00, 24, 0, c);
            check("reg_after_reset", c, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_3w_slave.md
SPI_3W_SLAVE -- requirements
Module: spi_3w_slave

Interface
REQ-001 SHALL have parameter SPI_Command_Len, default 16, giving the number of command bits per frame.
REQ-002 SHALL have parameter SPI_Data_Len, default 8, giving the number of data bits per frame.
REQ-003 SHALL have parameter Chip_ID, default 8'h92, giving the read-only value of register 0.
REQ-004 SHALL have port SPI_CLK, input, 1 bit: serial clock; sole clock of the block.
REQ-005 SHALL have port nReset, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port nCS, input, 1 bit: frame select, active-low; high aborts or ends a frame asynchronously.
REQ-007 SHALL have port SDIO_In, input, 1 bit: serial data from the bridge.
REQ-008 SHALL have port SDIO_Out, output, 1 bit: serial read data toward the bridge.
REQ-009 SHALL have port SDIO_OE, output, 1 bit: output enable for the shared data line.
REQ-010 SHALL have port Reg_Addr_Last, output, 5 bits: address of the last completed frame.
REQ-011 SHALL have port Write_Strobe, output, 1 bit: one-SPI_CLK pulse on each committed write.

Function
REQ-012 SHALL sample SDIO_In on the rising edge of SPI_CLK only while nCS=0.
REQ-013 SHALL keep a 5-bit bit counter: incremented per rising edge, saturating at SPI_Command_Len+SPI_Data_Len (24), cleared while nCS=1.
REQ-014 SHALL store bits LSB-index first: the bit at counter value k goes to shift word bit k.
REQ-015 SHALL decode shift-word bit 0 as R/nW (1 = read, 0 = write); the flag is fixed at bit 0 for the rest of the frame.
REQ-016 SHALL decode address = shift-word bits [5:1]; command bits [15:6] are ignored.
REQ-017 SHALL provide 32 x 8-bit registers; register 0 reads Chip_ID and ignores writes.
REQ-018 Write frame: on the 24th rising edge, SHALL commit bits [23:16] to the addressed register and pulse Write_Strobe high for that one cycle.
REQ-019 Read frame: on the falling edge after the 16th rising edge, SHALL assert SDIO_OE and drive data bit 0 on SDIO_Out; each following falling edge SHALL drive the next bit through bit 7.
REQ-020 Read frame: SHALL deassert SDIO_OE on the falling edge after the 24th rising edge, or immediately when nCS=1.
REQ-021 Read frame: SHALL latch the read data into an 8-bit TX shift register at the 16th rising edge, so a concurrent write cannot corrupt it.
REQ-022 SHALL keep SDIO_OE=0 for the whole of a write frame and during the command phase of a read.
REQ-023 SHALL ignore rising edges beyond 24 within a frame: no second write, no further drive.
REQ-024 nCS rising before the 24th edge SHALL abort the frame: no write, no Write_Strobe, counter cleared.
REQ-025 SHALL update Reg_Addr_Last at the 24th rising edge of any completed frame.
REQ-026 SDIO_Out SHALL be 0 whenever SDIO_OE=0.

Reset
REQ-027 nReset=0 SHALL asynchronously clear the bit counter, shift word, TX register, Write_Strobe, SDIO_OE, SDIO_Out and Reg_Addr_Last to 0.
REQ-028 nReset=0 SHALL clear registers 1-31 to 8'h00; register 0 remains Chip_ID.
REQ-029 Reset asserted mid-frame SHALL discard the frame; the next frame starts only after nCS has returned high.

Structure
REQ-030 SHALL place SPI_Command_Len, SPI_Data_Len, address width 5, Chip_ID default and bit-position constants (RW bit 0, address [5:1]) in the shared package spi_bridge_pkg.
REQ-031 SHALL contain one sub-module, spi_3w_regfile (32x8, register 0 read-only, async-reset), instantiated once.

Verification
REQ-032 Write frame, bit0=0, addr=5, data=8'hA5 -> reg5=8'hA5, single Write_Strobe at edge 24, SDIO_OE=0 throughout.
REQ-033 Read addr 5 after REQ-032 -> SDIO_OE rises at falling edge 16, bits 1,0,1,0,0,1,0,1 sampled on rising edges 17-24, OE falls at falling edge 24.
REQ-034 Read addr 0 -> 8'h92 returned; write 8'h00 to addr 0 then read -> still 8'h92.
REQ-035 Write addr 7 with 8'h3C, nCS raised after 20 edges -> reg7 unchanged at 8'h00, no Write_Strobe.
REQ-036 Write frame with 30 clocks -> exactly one write and one strobe; pulse nReset during a read at edge 19 -> SDIO_OE=0 immediately, reg1-31=8'h00.
